// File: rtl/coreir_repack_pkg.sv
// rtl/coreir_repack_pkg.sv - shared sizing helpers for the coreir_repack gearbox
//
// Contents:
//   calc_buf_w(in_width, out_width) : bit buffer width, in_width + out_width
//   calc_cnt_w(in_width, out_width) : width of an occupancy count 0..buf_w
package coreir_repack_pkg;

    function automatic int unsigned calc_buf_w(input int unsigned in_width,
                                               input int unsigned out_width);
        return in_width + out_width;
    endfunction

    function automatic int unsigned calc_cnt_w(input int unsigned in_width,
                                               input int unsigned out_width);
        return $clog2(in_width + out_width + 1);
    endfunction

endpackage

// File: rtl/coreir_repack_if.sv
// rtl/coreir_repack_if.sv - input/output stream handshake bundle for coreir_repack
//
// Signals:
//   in_valid, in_ready, in_data[in_width]     : input word stream
//   out_valid, out_ready, out_data[out_width] : output word stream
// Modports:
//   master : the environment (drives input stream, consumes output stream)
//   slave  : the gearbox
interface coreir_repack_if #(
    parameter int unsigned in_width  = 32'd4,
    parameter int unsigned out_width = 32'd12
) ();
    logic                 in_valid;
    logic                 in_ready;
    logic [in_width-1:0]  in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [out_width-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/coreir_repack_bitbuf.sv
// rtl/coreir_repack_bitbuf.sv - combinational next-state of the gearbox bit buffer
//
// Ports:
//   buf_q   in  : current buffer contents, bits at or above cnt are zero
//   cnt     in  : current occupancy
//   accept  in  : insert in_data this cycle
//   emit    in  : drop the lowest out_width bits this cycle
//   in_data in  : word to insert
//   buf_d   out : next buffer contents
module coreir_repack_bitbuf
    import coreir_repack_pkg::*;
#(
    parameter int unsigned in_width  = 32'd4,
    parameter int unsigned out_width = 32'd12,
    localparam int unsigned buf_w    = calc_buf_w(in_width, out_width),
    localparam int unsigned cnt_w    = calc_cnt_w(in_width, out_width)
) (
    input  logic [buf_w-1:0]    buf_q,
    input  logic [cnt_w-1:0]    cnt,
    input  logic                accept,
    input  logic                emit,
    input  logic [in_width-1:0] in_data,
    output logic [buf_w-1:0]    buf_d
);
    logic [buf_w-1:0] shifted;
    logic [cnt_w-1:0] base;
    logic [buf_w-1:0] word;

    always_comb begin
        shifted = buf_q;
        base    = cnt;
        if (emit) begin
            shifted = buf_q >> out_width;
            base    = cnt - cnt_w'(out_width);
        end
        // The region at and above base is already zero, so OR acts as an insert.
        word  = {{out_width{1'b0}}, in_data} << base;
        buf_d = accept ? (shifted | word) : shifted;
    end
endmodule

// File: rtl/coreir_repack.sv
// rtl/coreir_repack.sv - streaming gearbox repacking in_width-bit words into out_width-bit words
//
// Optional feature macro: COREIR_REPACK_FLUSH_EN (adds flush port and residual flush)
// Ports:
//   clk    in  : clock, all state on rising edge
//   arst_n in  : asynchronous active-low reset
//   bus        : coreir_repack_if.slave (in_valid/in_ready/in_data, out_valid/out_ready/out_data)
//   flush  in  : (COREIR_REPACK_FLUSH_EN only) emit residual bits zero-padded
module coreir_repack
    import coreir_repack_pkg::*;
#(
    parameter int unsigned in_width  = 32'd4,
    parameter int unsigned out_width = 32'd12
) (
    input  logic            clk,
    input  logic            arst_n,
    coreir_repack_if.slave  bus
`ifdef COREIR_REPACK_FLUSH_EN
    ,
    input  logic            flush
`endif
);
    localparam int unsigned buf_w = calc_buf_w(in_width, out_width);
    localparam int unsigned cnt_w = calc_cnt_w(in_width, out_width);
    localparam logic [cnt_w-1:0] iw_cnt = cnt_w'(in_width);
    localparam logic [cnt_w-1:0] ow_cnt = cnt_w'(out_width);

    logic [buf_w-1:0] buf_q;
    logic [buf_w-1:0] buf_d;
    logic [cnt_w-1:0] cnt;
    logic [cnt_w-1:0] cnt_d;
    logic             flush_pend;
    logic             in_ready_w;
    logic             out_valid_w;
    logic             accept;
    logic             emit;

    // cnt + in_width <= buf_w reduces to cnt <= out_width; no dependence on out_ready.
    assign in_ready_w  = !flush_pend && (cnt <= ow_cnt);
    assign out_valid_w = flush_pend || (cnt >= ow_cnt);
    assign accept      = bus.in_valid && in_ready_w;
    assign emit        = out_valid_w && bus.out_ready;

    assign bus.in_ready  = in_ready_w;
    assign bus.out_valid = out_valid_w;
    assign bus.out_data  = buf_q[out_width-1:0];

    always_comb begin
        cnt_d = cnt;
        if (emit && flush_pend) begin
            cnt_d = '0;
        end else begin
            case ({accept, emit})
                2'b10:   cnt_d = cnt + iw_cnt;
                2'b01:   cnt_d = cnt - ow_cnt;
                2'b11:   cnt_d = cnt - ow_cnt + iw_cnt;
                default: cnt_d = cnt;
            endcase
        end
    end

    // A flushed emit needs no special buffer handling: all residual bits sit
    // below out_width, so the normal shift leaves an all-zero buffer.
    coreir_repack_bitbuf #(
        .in_width  (in_width),
        .out_width (out_width)
    ) u_bitbuf (
        .buf_q   (buf_q),
        .cnt     (cnt),
        .accept  (accept),
        .emit    (emit),
        .in_data (bus.in_data),
        .buf_d   (buf_d)
    );

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            cnt   <= '0;
            buf_q <= '0;
        end else begin
            cnt   <= cnt_d;
            buf_q <= buf_d;
        end
    end

`ifdef COREIR_REPACK_FLUSH_EN
    logic flush_pend_d;

    // Arm only for a true partial word; if a same-cycle accept completes the
    // word, the flush is moot and the word leaves normally.
    always_comb begin
        flush_pend_d = flush_pend;
        if (flush_pend) begin
            if (emit) flush_pend_d = 1'b0;
        end else if (flush && (cnt != '0) && (cnt < ow_cnt)
                     && (cnt_d != '0) && (cnt_d < ow_cnt)) begin
            flush_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) flush_pend <= 1'b0;
        else         flush_pend <= flush_pend_d;
    end
`else
    assign flush_pend = 1'b0;
`endif
endmodule

// File: tb/tb_coreir_repack.sv
// tb/tb_coreir_repack.sv - self-checking bench for coreir_repack (4/12, 16/12, 12/12)
module tb_coreir_repack;
    logic clk = 1'b0;
    logic arst_n;
    always #5 clk = ~clk;

    coreir_repack_if #(.in_width(4),  .out_width(12)) a_if ();
    coreir_repack_if #(.in_width(16), .out_width(12)) w_if ();
    coreir_repack_if #(.in_width(12), .out_width(12)) e_if ();

`ifdef COREIR_REPACK_FLUSH_EN
    logic flush_a = 1'b0;
    logic flush_w = 1'b0;
    logic flush_e = 1'b0;
`endif

    coreir_repack #(.in_width(4), .out_width(12)) u_a (
        .clk(clk), .arst_n(arst_n), .bus(a_if)
`ifdef COREIR_REPACK_FLUSH_EN
        , .flush(flush_a)
`endif
    );
    coreir_repack #(.in_width(16), .out_width(12)) u_w (
        .clk(clk), .arst_n(arst_n), .bus(w_if)
`ifdef COREIR_REPACK_FLUSH_EN
        , .flush(flush_w)
`endif
    );
    coreir_repack #(.in_width(12), .out_width(12)) u_e (
        .clk(clk), .arst_n(arst_n), .bus(e_if)
`ifdef COREIR_REPACK_FLUSH_EN
        , .flush(flush_e)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit mq[$];   // reference model: accepted bits, oldest first

    function automatic void m_push(input int iw, input logic [15:0] d);
        for (int i = 0; i < iw; i++) mq.push_back(d[i]);
    endfunction

    function automatic logic [11:0] m_word(input int ow);
        logic [11:0] w = '0;
        for (int i = 0; i < ow && i < mq.size(); i++) w[i] = mq[i];
        return w;
    endfunction

    function automatic void m_pop(input int ow);
        for (int i = 0; i < ow && mq.size() > 0; i++) void'(mq.pop_front());
    endfunction

    // Sample outputs at the current negedge, drive inputs, advance one cycle.
    task automatic step(input int sel, input logic iv, input logic [15:0] id, input logic ordy,
                        output logic ir, output logic ov, output logic [11:0] od);
        case (sel)
            0: begin
                ir = a_if.in_ready; ov = a_if.out_valid; od = a_if.out_data;
                a_if.in_valid = iv; a_if.in_data = id[3:0]; a_if.out_ready = ordy;
            end
            1: begin
                ir = w_if.in_ready; ov = w_if.out_valid; od = w_if.out_data;
                w_if.in_valid = iv; w_if.in_data = id; w_if.out_ready = ordy;
            end
            default: begin
                ir = e_if.in_ready; ov = e_if.out_valid; od = e_if.out_data;
                e_if.in_valid = iv; e_if.in_data = id[11:0]; e_if.out_ready = ordy;
            end
        endcase
        @(negedge clk);
        a_if.in_valid = 1'b0; a_if.out_ready = 1'b0;
        w_if.in_valid = 1'b0; w_if.out_ready = 1'b0;
        e_if.in_valid = 1'b0; e_if.out_ready = 1'b0;
    endtask

    task automatic do_reset();
        arst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        arst_n = 1'b1;
        mq.delete();
    endtask

    task automatic test_reset();
        arst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_checks += 9;
        if (a_if.in_ready !== 1'b1)   begin n_fail++; $display("FAIL reset_a_in_ready got %b want 1", a_if.in_ready); end
        if (a_if.out_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_a_out_valid got %b want 0", a_if.out_valid); end
        if (a_if.out_data !== 12'h0)  begin n_fail++; $display("FAIL reset_a_out_data got %h want 000", a_if.out_data); end
        if (w_if.in_ready !== 1'b1)   begin n_fail++; $display("FAIL reset_w_in_ready got %b want 1", w_if.in_ready); end
        if (w_if.out_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_w_out_valid got %b want 0", w_if.out_valid); end
        if (w_if.out_data !== 12'h0)  begin n_fail++; $display("FAIL reset_w_out_data got %h want 000", w_if.out_data); end
        if (e_if.in_ready !== 1'b1)   begin n_fail++; $display("FAIL reset_e_in_ready got %b want 1", e_if.in_ready); end
        if (e_if.out_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_e_out_valid got %b want 0", e_if.out_valid); end
        if (e_if.out_data !== 12'h0)  begin n_fail++; $display("FAIL reset_e_out_data got %h want 000", e_if.out_data); end
        arst_n = 1'b1;
        mq.delete();
    endtask

    task automatic test_basic();
        logic ir, ov; logic [11:0] od;
        do_reset();
        step(0, 1, 16'h1, 0, ir, ov, od);
        n_checks++; if (ir !== 1'b1) begin n_fail++; $display("FAIL basic_ready got %b want 1", ir); end
        step(0, 1, 16'h2, 0, ir, ov, od);
        step(0, 1, 16'h3, 0, ir, ov, od);
        n_checks++; if (ov !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid got %b want 0", ov); end
        step(0, 0, 16'h0, 0, ir, ov, od);
        n_checks++; if (ov !== 1'b1)   begin n_fail++; $display("FAIL basic_valid got %b want 1", ov); end
        n_checks++; if (od !== 12'h321) begin n_fail++; $display("FAIL basic_data got %h want 321", od); end
        step(0, 0, 16'h0, 1, ir, ov, od);
        step(0, 0, 16'h0, 0, ir, ov, od);
        n_checks++; if (ov !== 1'b0 || ir !== 1'b1) begin
            n_fail++; $display("FAIL basic_drained got valid=%b ready=%b want 0/1", ov, ir);
        end
    endtask

    task automatic test_wide();
        logic ir, ov; logic [11:0] od;
        logic [15:0] words [3];
        logic [11:0] want [4];
        logic [11:0] outs[$];
        int idx = 0;
        int k   = 0;
        words = '{16'hABCD, 16'h1234, 16'h5678};
        want  = '{12'hBCD, 12'h34A, 12'h812, 12'h567};
        do_reset();
        while ((idx < 3 || outs.size() < 4) && k < 30) begin
            step(1, idx < 3, (idx < 3) ? words[idx] : 16'h0, 1, ir, ov, od);
            if (ov) outs.push_back(od);
            if (idx < 3 && ir) idx++;
            k++;
        end
        n_checks++; if (outs.size() != 4) begin n_fail++; $display("FAIL wide_count got %0d want 4", outs.size()); end
        for (int i = 0; i < 4 && i < outs.size(); i++) begin
            n_checks++;
            if (outs[i] !== want[i]) begin n_fail++; $display("FAIL wide_word%0d got %h want %h", i, outs[i], want[i]); end
        end
        step(1, 0, 16'h0, 0, ir, ov, od);
        n_checks++; if (ov !== 1'b0 || ir !== 1'b1 || od !== 12'h0) begin
            n_fail++; $display("FAIL wide_empty got valid=%b ready=%b data=%h want 0/1/000", ov, ir, od);
        end
    endtask

    task automatic test_backpressure();
        logic ir, ov; logic [11:0] od, held;
        logic [15:0] d;
        do_reset();
        for (int k = 0; k < 7; k++) begin
            d = 16'($urandom);
            step(0, 1, d, 0, ir, ov, od);
            n_checks++;
            if (ir !== (mq.size() + 4 <= 16)) begin n_fail++; $display("FAIL bp_ready%0d got %b want %b", k, ir, mq.size() + 4 <= 16); end
            if (k >= 4) begin
                n_checks++; if (ir !== 1'b0) begin n_fail++; $display("FAIL bp_full%0d got %b want 0", k, ir); end
            end
            if (ir) m_push(4, d);
        end
        held = m_word(12);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 16'h0, (k == 2), ir, ov, od);
            n_checks++;
            if (ov !== 1'b1 || od !== held) begin n_fail++; $display("FAIL bp_hold%0d got %b/%h want 1/%h", k, ov, od, held); end
        end
        m_pop(12);
        step(0, 0, 16'h0, 0, ir, ov, od);
        n_checks++; if (ir !== 1'b1) begin n_fail++; $display("FAIL bp_restore got %b want 1", ir); end
    endtask

    task automatic test_flow();
        logic ir, ov; logic [11:0] od;
        logic [11:0] d, prev;
        do_reset();
        prev = '0;
        for (int k = 0; k < 20; k++) begin
            d = 12'($urandom);
            step(2, 1, {4'h0, d}, 1, ir, ov, od);
            n_checks++; if (ir !== 1'b1) begin n_fail++; $display("FAIL flow_ready%0d got %b want 1", k, ir); end
            n_checks++;
            if (k == 0) begin
                if (ov !== 1'b0) begin n_fail++; $display("FAIL flow_first got %b want 0", ov); end
            end else if (ov !== 1'b1 || od !== prev) begin
                n_fail++; $display("FAIL flow_word%0d got %b/%h want 1/%h", k, ov, od, prev);
            end
            prev = d;
        end
        step(2, 0, 16'h0, 1, ir, ov, od);
        n_checks++; if (ov !== 1'b1 || od !== prev) begin n_fail++; $display("FAIL flow_last got %b/%h want 1/%h", ov, od, prev); end
        step(2, 0, 16'h0, 0, ir, ov, od);
        n_checks++; if (ov !== 1'b0) begin n_fail++; $display("FAIL flow_empty got %b want 0", ov); end
    endtask

    task automatic test_random(input int sel, input int iw, input int n);
        logic ir, ov; logic [11:0] od;
        logic iv, ordy, exp_ir, exp_ov;
        logic [15:0] d;
        do_reset();
        for (int k = 0; k < n; k++) begin
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            d    = 16'($urandom);
            step(sel, iv, d, ordy, ir, ov, od);
            exp_ir = (mq.size() + iw <= iw + 12);
            exp_ov = (mq.size() >= 12);
            n_checks += 2;
            if (ir !== exp_ir) begin n_fail++; $display("FAIL rand%0d_ready step %0d got %b want %b", sel, k, ir, exp_ir); end
            if (ov !== exp_ov) begin n_fail++; $display("FAIL rand%0d_valid step %0d got %b want %b", sel, k, ov, exp_ov); end
            if (exp_ov) begin
                n_checks++;
                if (od !== m_word(12)) begin n_fail++; $display("FAIL rand%0d_data step %0d got %h want %h", sel, k, od, m_word(12)); end
                if (ordy) m_pop(12);
            end
            if (iv && exp_ir) m_push(iw, d);
        end
    endtask

    task automatic test_reset_mid();
        logic ir, ov; logic [11:0] od;
        do_reset();
        step(0, 1, 16'h1, 0, ir, ov, od);
        step(0, 1, 16'h2, 0, ir, ov, od);
        arst_n = 1'b0;
        #1;
        n_checks++; if (a_if.out_valid !== 1'b0 || a_if.in_ready !== 1'b1 || a_if.out_data !== 12'h0) begin
            n_fail++; $display("FAIL midreset got valid=%b ready=%b data=%h want 0/1/000", a_if.out_valid, a_if.in_ready, a_if.out_data);
        end
        @(negedge clk);
        arst_n = 1'b1;
        mq.delete();
        step(0, 1, 16'h4, 0, ir, ov, od);
        step(0, 1, 16'h5, 0, ir, ov, od);
        step(0, 1, 16'h6, 0, ir, ov, od);
        step(0, 0, 16'h0, 0, ir, ov, od);
        n_checks++; if (ov !== 1'b1 || od !== 12'h654) begin n_fail++; $display("FAIL midreset_restart got %b/%h want 1/654", ov, od); end
    endtask

`ifdef COREIR_REPACK_FLUSH_EN
    task automatic test_flush();
        logic ir, ov; logic [11:0] od;
        do_reset();
        step(0, 1, 16'hA, 0, ir, ov, od);
        step(0, 1, 16'hB, 0, ir, ov, od);
        flush_a = 1'b1;
        step(0, 0, 16'h0, 0, ir, ov, od);
        flush_a = 1'b0;
        step(0, 1, 16'h7, 0, ir, ov, od);
        n_checks++; if (ov !== 1'b1 || ir !== 1'b0 || od !== 12'h0BA) begin
            n_fail++; $display("FAIL flush_pending got valid=%b ready=%b data=%h want 1/0/0ba", ov, ir, od);
        end
        step(0, 0, 16'h0, 1, ir, ov, od);
        step(0, 0, 16'h0, 0, ir, ov, od);
        n_checks++; if (ov !== 1'b0 || ir !== 1'b1 || od !== 12'h0) begin
            n_fail++; $display("FAIL flush_done got valid=%b ready=%b data=%h want 0/1/000", ov, ir, od);
        end
        flush_a = 1'b1;
        step(0, 0, 16'h0, 0, ir, ov, od);
        flush_a = 1'b0;
        step(0, 0, 16'h0, 0, ir, ov, od);
        n_checks++; if (ov !== 1'b0 || ir !== 1'b1) begin
            n_fail++; $display("FAIL flush_empty got valid=%b ready=%b want 0/1", ov, ir);
        end
    endtask
`endif

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        a_if.in_valid = 1'b0; a_if.in_data = '0; a_if.out_ready = 1'b0;
        w_if.in_valid = 1'b0; w_if.in_data = '0; w_if.out_ready = 1'b0;
        e_if.in_valid = 1'b0; e_if.in_data = '0; e_if.out_ready = 1'b0;
        arst_n = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_wide();
        test_backpressure();
        test_flow();
        test_random(0, 4, 300);
        test_random(1, 16, 300);
        test_random(2, 12, 200);
        test_reset_mid();
`ifdef COREIR_REPACK_FLUSH_EN
        test_flush();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
